// File: rtl/wb_fifo_slave.sv
// wb_fifo_slave: Wishbone classic slave that fronts a DEPTH-word FIFO mailbox.
//   Word 0 DATA    : write pushes, read pops (err on full / empty)
//   Word 1 STATUS  : RO {count[15:8], irq[2], full[1], empty[0]}
//   Word 2 CONTROL : write with bit0=1 flushes; read returns 0
//   Word 3         : reserved, always err
// Ports:
//   clk_i, rst_i (sync, active high)
//   cyc_i, stb_i, we_i, adr_i, dat_i, sel_i  : bus request (sel_i ignored)
//   ack_o, err_o, dat_o                      : registered one-cycle response
//   irq_o                                    : registered level, count >= IRQ_LEVEL
module wb_fifo_slave #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8,
   parameter int IRQ_LEVEL  = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  cyc_i,
   input  logic                  stb_i,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] adr_i,
   input  logic [DATA_WIDTH-1:0] dat_i,
   input  logic [3:0]            sel_i,
   output logic                  ack_o,
   output logic                  err_o,
   output logic [DATA_WIDTH-1:0] dat_o,
   output logic                  irq_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic {IDLE, RESP} state_t;

   state_t                state_q, state_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  ack_q, ack_d;
   logic                  err_q, err_d;
   logic [DATA_WIDTH-1:0] dat_q, dat_d;
   logic                  irq_q, irq_d;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic                  req, full, empty, push;
   logic [DATA_WIDTH-1:0] status_w;
   logic                  unused_bits;

   // Only the word offset matters; byte lanes and upper address bits are don't-care.
   assign unused_bits = ^{sel_i, adr_i[ADDR_WIDTH-1:4], adr_i[1:0]};

   assign req   = cyc_i & stb_i;
   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);

   always_comb begin
      status_w       = '0;
      status_w[0]    = empty;
      status_w[1]    = full;
      status_w[2]    = irq_q;
      status_w[15:8] = 8'(count_q);
   end

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ack_d    = 1'b0;
      err_d    = 1'b0;
      dat_d    = '0;
      push     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req) begin
               state_d = RESP;
               case (adr_i[3:2])
                  2'd0: begin
                     if (we_i) begin
                        if (full) err_d = 1'b1;
                        else begin
                           ack_d    = 1'b1;
                           push     = 1'b1;
                           wr_ptr_d = wr_ptr_q + PW'(1);
                           count_d  = count_q + CW'(1);
                        end
                     end else begin
                        if (empty) err_d = 1'b1;
                        else begin
                           ack_d    = 1'b1;
                           dat_d    = mem_q[rd_ptr_q];
                           rd_ptr_d = rd_ptr_q + PW'(1);
                           count_d  = count_q - CW'(1);
                        end
                     end
                  end
                  2'd1: begin
                     ack_d = 1'b1;
                     if (!we_i) dat_d = status_w;
                  end
                  2'd2: begin
                     ack_d = 1'b1;
                     if (we_i && dat_i[0]) begin
                        wr_ptr_d = '0;
                        rd_ptr_d = '0;
                        count_d  = '0;
                     end
                  end
                  default: err_d = 1'b1;
               endcase
            end
         end
         RESP: state_d = IDLE;
      endcase
      // irq follows the new count so it is already valid in the RESP cycle.
      irq_d = (count_d >= CW'(IRQ_LEVEL));
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
         dat_q    <= '0;
         irq_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ack_q    <= ack_d;
         err_q    <= err_d;
         dat_q    <= dat_d;
         irq_q    <= irq_d;
      end
   end

   // Storage needs no reset; only words between the pointers are ever read.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= dat_i;
   end

   assign ack_o = ack_q;
   assign err_o = err_q;
   assign dat_o = dat_q;
   assign irq_o = irq_q;
endmodule

// File: tb/tb_wb_fifo_slave.sv
// Bench for wb_fifo_slave: fixed vector table, hand sequences for reset/stream
// corners, and random accesses checked against a queue-based mailbox model.
module tb_wb_fifo_slave;
   localparam int AW = 16, DW = 32, DEPTH = 8, IRQL = 4;

   logic          clk_i = 1'b0, rst_i = 1'b1;
   logic          cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0;
   logic [AW-1:0] adr_i = '0;
   logic [DW-1:0] dat_i = '0;
   logic [3:0]    sel_i = 4'hF;
   logic          ack_o, err_o, irq_o;
   logic [DW-1:0] dat_o;

   wb_fifo_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .IRQ_LEVEL(IRQL)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
      .adr_i(adr_i), .dat_i(dat_i), .sel_i(sel_i),
      .ack_o(ack_o), .err_o(err_o), .dat_o(dat_o), .irq_o(irq_o));

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic          we;
      logic [AW-1:0] adr;
      logic [DW-1:0] dat;
      logic          ack;
      logic          err;
      logic [DW-1:0] rdat;
      logic          irq;
   } vec_t;

   vec_t          vq[$];
   logic [DW-1:0] model_q[$];
   int            n_total = 0, n_pass = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic void add(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                               input logic ack, input logic err, input logic [DW-1:0] rdat,
                               input logic irq);
      vq.push_back('{we, adr, dat, ack, err, rdat, irq});
   endfunction

   // Mailbox reference: behaviour of one access in terms of a plain queue.
   task automatic model_access(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                               output logic ack, output logic err, output logic [DW-1:0] rdat,
                               output logic irq);
      int n;
      ack = 1'b0; err = 1'b0; rdat = '0;
      n = model_q.size();
      case (adr[3:2])
         2'd0: if (we) begin
                  if (n == DEPTH) err = 1'b1;
                  else begin ack = 1'b1; model_q.push_back(dat); end
               end else begin
                  if (n == 0) err = 1'b1;
                  else begin ack = 1'b1; rdat = model_q.pop_front(); end
               end
         2'd1: begin
                  ack = 1'b1;
                  if (!we) rdat = (n * 256) + ((n >= IRQL) ? 4 : 0) + ((n == DEPTH) ? 2 : 0)
                                  + ((n == 0) ? 1 : 0);
               end
         2'd2: begin
                  ack = 1'b1;
                  if (we && dat[0]) model_q.delete();
               end
         default: err = 1'b1;
      endcase
      irq = (model_q.size() >= IRQL);
   endtask

   // One bus access: response sampled in the cycle after the request edge,
   // then checked to have gone away one cycle later.
   task automatic acc(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                      output logic ack, output logic err, output logic [DW-1:0] rdat,
                      output logic irq);
      @(negedge clk_i);
      cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; dat_i = dat;
      @(posedge clk_i); #1;
      ack = ack_o; err = err_o; rdat = dat_o; irq = irq_o;
      cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
      @(posedge clk_i); #1;
      check("resp_one_cycle", {62'd0, ack_o, err_o}, 64'd0);
   endtask

   task automatic acc_model(input string name, input logic we, input logic [AW-1:0] adr,
                            input logic [DW-1:0] dat);
      logic a, e, i, ma, me, mi;
      logic [DW-1:0] r, mr;
      model_access(we, adr, dat, ma, me, mr, mi);
      acc(we, adr, dat, a, e, r, i);
      check(name, {29'd0, a, e, i, r}, {29'd0, ma, me, mi, mr});
   endtask

   task automatic do_reset();
      @(negedge clk_i); rst_i = 1'b1;
      @(posedge clk_i); @(negedge clk_i); rst_i = 1'b0;
      model_q.delete();
   endtask

   initial begin
      logic a, e, i;
      logic [DW-1:0] r;

      // Reset state
      repeat (3) @(posedge clk_i);
      #1;
      check("reset_outputs", {30'd0, ack_o, err_o, irq_o, dat_o}, 64'd0);
      @(negedge clk_i); rst_i = 1'b0;

      // Directed vector table
      add(0, 16'h004, 0, 1, 0, 32'h1, 0);
      add(1, 16'h000, 32'h11, 1, 0, 0, 0);
      add(1, 16'h000, 32'h22, 1, 0, 0, 0);
      add(1, 16'h000, 32'h33, 1, 0, 0, 0);
      add(1, 16'h000, 32'h44, 1, 0, 0, 1);
      add(0, 16'h004, 0, 1, 0, 32'h404, 1);
      add(1, 16'h000, 32'h55, 1, 0, 0, 1);
      add(1, 16'h000, 32'h66, 1, 0, 0, 1);
      add(1, 16'h000, 32'h77, 1, 0, 0, 1);
      add(1, 16'h000, 32'h88, 1, 0, 0, 1);
      add(1, 16'h000, 32'hDEAD, 0, 1, 0, 1);
      add(0, 16'h004, 0, 1, 0, 32'h806, 1);
      add(0, 16'h000, 0, 1, 0, 32'h11, 1);
      add(0, 16'h000, 0, 1, 0, 32'h22, 1);
      add(0, 16'h000, 0, 1, 0, 32'h33, 1);
      add(0, 16'h000, 0, 1, 0, 32'h44, 1);
      add(0, 16'h000, 0, 1, 0, 32'h55, 0);
      add(0, 16'h000, 0, 1, 0, 32'h66, 0);
      add(0, 16'h000, 0, 1, 0, 32'h77, 0);
      add(0, 16'h000, 0, 1, 0, 32'h88, 0);
      add(0, 16'h000, 0, 0, 1, 0, 0);
      add(1, 16'h008, 32'h1, 1, 0, 0, 0);
      add(1, 16'h000, 32'hAA, 1, 0, 0, 0);
      add(1, 16'h000, 32'hBB, 1, 0, 0, 0);
      add(1, 16'h000, 32'hCC, 1, 0, 0, 0);
      add(0, 16'h004, 0, 1, 0, 32'h300, 0);
      add(1, 16'h008, 32'h2, 1, 0, 0, 0);
      add(0, 16'h004, 0, 1, 0, 32'h300, 0);
      add(1, 16'h008, 32'h1, 1, 0, 0, 0);
      add(0, 16'h004, 0, 1, 0, 32'h1, 0);
      add(0, 16'h000, 0, 0, 1, 0, 0);
      add(0, 16'h008, 0, 1, 0, 0, 0);
      add(1, 16'h004, 32'hFFFF, 1, 0, 0, 0);
      add(0, 16'h004, 0, 1, 0, 32'h1, 0);
      add(0, 16'h00C, 0, 0, 1, 0, 0);
      add(1, 16'h00C, 32'h1, 0, 1, 0, 0);
      add(0, 16'h004, 0, 1, 0, 32'h1, 0);
      foreach (vq[k]) begin
         acc(vq[k].we, vq[k].adr, vq[k].dat, a, e, r, i);
         check($sformatf("vec%0d", k), {29'd0, a, e, i, r},
               {29'd0, vq[k].ack, vq[k].err, vq[k].irq, vq[k].rdat});
      end

      // Reset asserted during the RESP cycle of a push
      @(negedge clk_i);
      cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 16'h000; dat_i = 32'h77;
      @(posedge clk_i); #1;
      check("rst_resp_ack", {63'd0, ack_o}, 64'd1);
      rst_i = 1'b1; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
      @(posedge clk_i); #1;
      check("rst_resp_cleared", {62'd0, ack_o, err_o}, 64'd0);
      rst_i = 1'b0;
      model_q.delete();
      acc_model("rst_resp_status", 0, 16'h004, 0);

      // Continuous strobe: one response every other cycle, never ack with err
      @(negedge clk_i);
      cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 16'h004;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk_i); #1;
         check($sformatf("stream%0d", k), {62'd0, ack_o, err_o}, {62'd0, (k % 2 == 1), 1'b0});
      end
      cyc_i = 1'b0; stb_i = 1'b0;
      @(posedge clk_i); #1;

      // Pointer wrap: push 6, pop 6, push 5, pop 5
      for (int k = 0; k < 6; k++) acc_model("wrap_push6", 1, 16'h000, 32'h100 + k);
      for (int k = 0; k < 6; k++) acc_model("wrap_pop6", 0, 16'h000, 0);
      for (int k = 0; k < 5; k++) acc_model("wrap_push5", 1, 16'h000, 32'h200 + k);
      for (int k = 0; k < 5; k++) acc_model("wrap_pop5", 0, 16'h000, 0);
      acc_model("wrap_status", 0, 16'h004, 0);

      // Flush while full
      for (int k = 0; k < DEPTH; k++) acc_model("ff_push", 1, 16'h000, $urandom);
      acc_model("ff_status", 0, 16'h004, 0);
      acc_model("ff_flush", 1, 16'h008, 32'h1);
      acc_model("ff_after", 0, 16'h004, 0);

      // Random traffic against the mailbox model
      do_reset();
      for (int k = 0; k < 400; k++) begin
         int       s;
         logic     w;
         logic [AW-1:0] ad;
         logic [DW-1:0] d;
         s = $urandom_range(0, 9);
         w = 1'($urandom_range(0, 1));
         ad = (s < 5) ? 16'h000 : (s < 7) ? 16'h004 : (s < 9) ? 16'h008 : 16'h00C;
         ad = ad | 16'($urandom_range(0, 15) << 4) | 16'($urandom_range(0, 3));
         d = $urandom;
         if (s == 7 || s == 8) d = ($urandom_range(0, 7) == 0) ? 32'h1 : (d & ~32'h1);
         acc_model($sformatf("rand%0d", k), w, ad, d);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
